// File: rtl/proc_mem_pkg.sv
// Shared constants and types for the processor memory arbiter.
package proc_mem_pkg;

  localparam int DEF_MEM_DEPTH  = 1024;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_MEM_DEPTH);

  // Bit positions in the internal one-hot grant vector
  localparam int PORT_IF = 0;
  localparam int PORT_LS = 1;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_LS
  } gnt_sel_e;

endpackage

// File: rtl/proc_mem_arb_sel.sv
// Combinational grant select: LS wins, except when IF has waited the full streak.
module proc_mem_arb_sel
  import proc_mem_pkg::*;
#(
  parameter int MAX_LS_STREAK = 4
) (
  input  logic       if_req_i,
  input  logic       ls_req_i,
  input  logic [3:0] streak_i,
  output logic [1:0] gnt_o
);

  localparam logic [3:0] MAX_STREAK = 4'(MAX_LS_STREAK);

  gnt_sel_e sel;

  // Pick the winner and expand it to a one-hot grant vector
  always_comb begin
    sel   = GNT_NONE;
    gnt_o = '0;
    if (ls_req_i && !(if_req_i && (streak_i == MAX_STREAK))) sel = GNT_LS;
    else if (if_req_i)                                        sel = GNT_IF;
    gnt_o[PORT_IF] = (sel == GNT_IF);
    gnt_o[PORT_LS] = (sel == GNT_LS);
  end

endmodule

// File: rtl/proc_mem_arbiter.sv
// Two-requester arbiter for the single-port processor memory (IF read, LS read/write).
module proc_mem_arbiter
  import proc_mem_pkg::*;
#(
  parameter  int DATA_WIDTH    = 32,
  parameter  int MEM_DEPTH     = DEF_MEM_DEPTH,
  parameter  int MAX_LS_STREAK = 4,
  localparam int ADDR_WIDTH    = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_add_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  ls_req_i,
  input  logic                  ls_we_i,
  input  logic [ADDR_WIDTH-1:0] ls_add_i,
  input  logic [DATA_WIDTH-1:0] ls_wdata_i,
  output logic                  ls_gnt_o,
  output logic                  ls_rvalid_o,
  output logic [DATA_WIDTH-1:0] ls_rdata_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_add_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam logic [3:0] MAX_STREAK = 4'(MAX_LS_STREAK);

  logic [1:0]            gnt;
  logic                  if_gnt, ls_gnt;
  logic [3:0]            streak_q, streak_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  ls_rvalid_q, ls_rvalid_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;

  proc_mem_arb_sel #(.MAX_LS_STREAK(MAX_LS_STREAK)) u_sel (
    .if_req_i (if_req_i),
    .ls_req_i (ls_req_i),
    .streak_i (streak_q),
    .gnt_o    (gnt)
  );

  // Grants are suppressed during reset so nothing reaches the memory
  assign if_gnt   = gnt[PORT_IF] & ~rst;
  assign ls_gnt   = gnt[PORT_LS] & ~rst;
  assign if_gnt_o = if_gnt;
  assign ls_gnt_o = ls_gnt;

  // Memory port mux; idle port is driven to all zeros
  always_comb begin
    mem_we_o    = 1'b0;
    mem_add_o   = '0;
    mem_wdata_o = '0;
    if (ls_gnt) begin
      mem_we_o    = ls_we_i;
      mem_add_o   = ls_add_i;
      mem_wdata_o = ls_wdata_i;
    end else if (if_gnt) begin
      mem_add_o   = if_add_i;
    end
  end

  // Next state: streak counter and one-cycle-latency responses
  always_comb begin
    streak_d = streak_q;
    if (!if_req_i || if_gnt)  streak_d = '0;
    else if (ls_gnt)          streak_d = (streak_q == MAX_STREAK) ? MAX_STREAK : streak_q + 4'd1;

    if_rvalid_d = if_gnt;
    if_rdata_d  = if_gnt ? mem_rdata_i : if_rdata_q;
    ls_rvalid_d = ls_gnt;
    ls_rdata_d  = (ls_gnt && !ls_we_i) ? mem_rdata_i : ls_rdata_q;
  end

  // State registers; reset drops any pending response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q    <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      streak_q    <= streak_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign ls_rdata_o  = ls_rdata_q;

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Directed bench for proc_mem_arbiter with a behavioural single-port memory.
module tb_proc_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk, rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_add;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [AW-1:0] ls_add;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_add;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_tests = 0;
  int n_fail  = 0;

  proc_mem_arbiter #(.DATA_WIDTH(DW), .MEM_DEPTH(1<<AW), .MAX_LS_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_add_i(if_add), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_add_i(ls_add), .ls_wdata_i(ls_wdata),
    .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
    .mem_we_o(mem_we), .mem_add_o(mem_add), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: combinational read, write at the grant-cycle edge
  assign mem_rdata = mem[mem_add];
  always @(posedge clk) if (mem_we) mem[mem_add] <= mem_wdata;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req = 0; if_add = '0; ls_req = 0; ls_we = 0; ls_add = '0; ls_wdata = '0;
    cyc; cyc;
    chk("rst if_rvalid", {31'd0, if_rvalid}, 0);
    chk("rst ls_rvalid", {31'd0, ls_rvalid}, 0);
    chk("rst if_rdata", if_rdata, 0);
    chk("rst ls_rdata", ls_rdata, 0);
    rst = 1'b0;

    // Preload mem[0x10] through the LS port, then reset while LS is still requesting
    ls_req = 1; ls_we = 1; ls_add = 10'h10; ls_wdata = 32'hDEADBEEF;
    #1 chk("pre ls_gnt", {31'd0, ls_gnt}, 1);
    chk("pre mem_we", {31'd0, mem_we}, 1);
    cyc;
    chk("pre wr ls_rvalid", {31'd0, ls_rvalid}, 1);
    chk("pre wr ls_rdata hold", ls_rdata, 0);
    #2 rst = 1'b1;
    #1 chk("rst mid ls_gnt", {31'd0, ls_gnt}, 0);
    chk("rst mid mem_we", {31'd0, mem_we}, 0);
    chk("rst mid ls_rvalid", {31'd0, ls_rvalid}, 0);
    ls_req = 0; ls_we = 0;
    cyc;
    rst = 1'b0;
    cyc;
    chk("post rst ls_rvalid", {31'd0, ls_rvalid}, 0);
    chk("post rst if_rvalid", {31'd0, if_rvalid}, 0);

    // IF-only read
    if_req = 1; if_add = 10'h10;
    #1 chk("if gnt", {31'd0, if_gnt}, 1);
    chk("if no ls_gnt", {31'd0, ls_gnt}, 0);
    chk("if mem_add", {22'd0, mem_add}, 32'h10);
    chk("if mem_we", {31'd0, mem_we}, 0);
    cyc;
    chk("if rvalid", {31'd0, if_rvalid}, 1);
    chk("if rdata", if_rdata, 32'hDEADBEEF);
    chk("if ls_rvalid", {31'd0, ls_rvalid}, 0);
    if_req = 0;
    cyc;
    chk("if rvalid pulse", {31'd0, if_rvalid}, 0);

    // LS write then read-back, back to back
    ls_req = 1; ls_we = 1; ls_add = 10'h20; ls_wdata = 32'h12345678;
    #1 chk("lsw gnt", {31'd0, ls_gnt}, 1);
    chk("lsw mem_we", {31'd0, mem_we}, 1);
    chk("lsw mem_wdata", mem_wdata, 32'h12345678);
    chk("lsw mem_add", {22'd0, mem_add}, 32'h20);
    cyc;
    chk("lsw rvalid", {31'd0, ls_rvalid}, 1);
    chk("lsw rdata hold", ls_rdata, 0);
    ls_we = 0;
    #1 chk("lsr gnt", {31'd0, ls_gnt}, 1);
    chk("lsr mem_we", {31'd0, mem_we}, 0);
    cyc;
    chk("lsr rvalid", {31'd0, ls_rvalid}, 1);
    chk("lsr rdata", ls_rdata, 32'h12345678);
    ls_req = 0;
    cyc;
    chk("lsr rvalid pulse", {31'd0, ls_rvalid}, 0);

    // Contention: LS,LS,LS,LS,IF repeating
    if_req = 1; if_add = 10'h10; ls_req = 1; ls_we = 0; ls_add = 10'h20;
    for (int k = 0; k < 10; k++) begin
      logic exp_if;
      exp_if = (k % 5 == 4);
      #1;
      chk($sformatf("cont if_gnt %0d", k), {31'd0, if_gnt}, {31'd0, exp_if});
      chk($sformatf("cont ls_gnt %0d", k), {31'd0, ls_gnt}, {31'd0, ~exp_if});
      cyc;
      chk($sformatf("cont if_rvalid %0d", k), {31'd0, if_rvalid}, {31'd0, exp_if});
      chk($sformatf("cont ls_rvalid %0d", k), {31'd0, ls_rvalid}, {31'd0, ~exp_if});
    end
    if_req = 0; ls_req = 0;
    cyc;

    // Streak clear: 2 LS grants with IF waiting, IF drops, then re-raised
    ls_req = 1; ls_we = 0; ls_add = 10'h20;
    cyc; cyc;
    if_req = 1;
    cyc; cyc;
    if_req = 0;
    cyc;
    if_req = 1;
    for (int k = 0; k < 5; k++) begin
      logic exp_if;
      exp_if = (k == 4);
      #1;
      chk($sformatf("clr if_gnt %0d", k), {31'd0, if_gnt}, {31'd0, exp_if});
      chk($sformatf("clr ls_gnt %0d", k), {31'd0, ls_gnt}, {31'd0, ~exp_if});
      cyc;
    end
    if_req = 0; ls_req = 0;
    cyc;

    // Idle: memory port quiet, responses hold
    for (int k = 0; k < 10; k++) begin
      cyc;
      chk("idle mem_we", {31'd0, mem_we}, 0);
      chk("idle mem_add", {22'd0, mem_add}, 0);
      chk("idle mem_wdata", mem_wdata, 0);
      chk("idle rvalids", {30'd0, if_rvalid, ls_rvalid}, 0);
    end
    chk("idle if_rdata", if_rdata, 32'hDEADBEEF);
    chk("idle ls_rdata", ls_rdata, 32'h12345678);

    // LS write keeps old ls_rdata; IF reads the freshly written word
    ls_req = 1; ls_we = 1; ls_add = 10'h30; ls_wdata = 32'hCAFEF00D;
    cyc;
    chk("w2 ls_rdata hold", ls_rdata, 32'h12345678);
    ls_req = 0; ls_we = 0;
    if_req = 1; if_add = 10'h30;
    cyc;
    chk("raw if_rdata", if_rdata, 32'hCAFEF00D);
    if_req = 0;
    cyc;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
